bcd_pulse_counter: RTL and testbench
====================================

Name: bcd_pulse_counter

Overview:
- Multi-digit BCD up/down counter. Sits directly downstream of the InputSanitizer stage on the Basys3 BCD_Counter design.
- Consumes the 4 debounced button levels, detects rising edges, and applies one counter command per press.
- Drives the packed BCD count to the seven-segment display stage and pulses on wrap-around.

Parameters:
- NumDigits, 4, number of BCD digits; count range 0 to 10^NumDigits-1.
- PresetValue, 16'h0000, packed BCD value loaded by the Load command. Width is 4*NumDigits. Every nibble must be 0-9.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DataIn  input  4  debounced levels: [0] Inc, [1] Dec, [2] Clear, [3] Load.
- Count  output  4*NumDigits  packed BCD count; digit 0 is in bits [3:0].
- Overflow  output  1  one-cycle pulse when an Inc wraps the maximum value to 0.
- Underflow  output  1  one-cycle pulse when a Dec wraps 0 to the maximum value.

Behaviour:
- Reset is asynchronous and active-high: Count=0, Overflow=0, Underflow=0, PrevIn=4'b1111.
  - PrevIn=4'b1111 means a button held through reset release produces no event.
- Edge detect: Rise[b] = DataIn[b] & ~PrevIn[b]. PrevIn<=DataIn every cycle.
- Latency: DataIn rises before edge k, so Rise is seen at edge k and Count updates at edge k. This is one clock after the input change. Overflow and Underflow are registered and are high only for the cycle following edge k.
- Holding a level high gives exactly one event. The next event needs a 0 to be sampled first.
- Command priority per cycle: Clear > Load > (Inc xor Dec).
  - Clear: Count<=0. No pulse.
  - Load: Count<=PresetValue. No pulse.
  - Inc and Dec rising on the same cycle: no change, no pulse.
  - Inc alone: BCD increment with ripple carry. A digit at 9 goes to 0 and carries into the next digit. If all digits are 9, Count<=0 and Overflow=1.
  - Dec alone: BCD decrement with ripple borrow. A digit at 0 goes to 9 and borrows from the next digit. If all digits are 0, Count<=all 9s and Underflow=1.
- No rising edge on any bit: Count holds, pulses are 0.
- Every digit of Count is always in the range 0-9. No binary-to-BCD conversion is used.
- Reset asserted mid-operation: outputs clear immediately, without waiting for Clk. A pending edge is discarded.

Optional Feature:
- Macro: BCD_COUNTER_SATURATE_EN.
- Defined:
  - Inc at all 9s holds all 9s and pulses Overflow.
  - Dec at 0 holds 0 and pulses Underflow.
  - The pulses then mean "at limit" and no wrap occurs.
- Undefined: wrap-around behaviour as specified above.

Decomposition:
- Shared package bcd_counter_pkg holds:
  - localparam bit indices IncBit=0, DecBit=1, ClearBit=2, LoadBit=3.
  - BCD constants BcdMax=4'd9, BcdMin=4'd0.
  - The digit width constant DigitWidth=4.
- One sub-module, bcd_digit, is natural. It is combinational and handles one digit:
  - Inputs: digit, Inc, Dec, carry/borrow in.
  - Outputs: next digit, carry out, borrow out.
- The top level instantiates NumDigits copies in a generate loop and owns all registers.

Test Plan (NumDigits=4 unless stated):
- Reset with DataIn=4'b0001 held, then release Reset and keep DataIn held. Count stays 16'h0000 (no spurious event). Drop DataIn to 0, then pulse bit0. Count=16'h0001 one clock later.
- From 16'h0009, pulse Inc: Count=16'h0010. From 16'h0999, pulse Inc: Count=16'h1000. Check that no nibble ever exceeds 9.
- From 16'h9999, pulse Inc: Count=16'h0000 and Overflow high for exactly 1 cycle. From 16'h0000, pulse Dec: Count=16'h9999 and Underflow high for 1 cycle. With BCD_COUNTER_SATURATE_EN, the counts instead hold at 16'h9999 and 16'h0000, with the same pulses.
- Hold Inc high for 10 clocks: count advances by exactly 1. Inc and Dec rising on the same cycle from 16'h0042: Count stays 16'h0042.
- From 16'h0042, raise DataIn=4'b1101 (Clear+Load+Inc) together: Count=16'h0000. Raise Load alone with PresetValue=16'h1234: Count=16'h1234.
- Assert Reset asynchronously between clock edges with Count=16'h0777: Count=16'h0000 before the next Clk edge. No event is applied on the edge after release.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared constants for the BCD pulse counter: button bit indices and BCD digit limits.
package bcd_counter_pkg;
  localparam int DigitWidth = 4;

  localparam int IncBit   = 0;
  localparam int DecBit   = 1;
  localparam int ClearBit = 2;
  localparam int LoadBit  = 3;

  localparam logic [DigitWidth-1:0] BcdMax = 4'd9;
  localparam logic [DigitWidth-1:0] BcdMin = 4'd0;
endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit slice: steps up or down when the ripple input is set
// and raises carry/borrow when it wraps.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic [DigitWidth-1:0] digit_i,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  logic                  cb_i,
  output logic [DigitWidth-1:0] digit_o,
  output logic                  carry_o,
  output logic                  borrow_o
);
  logic at_max, at_min;

  assign at_max = (digit_i == BcdMax);
  assign at_min = (digit_i == BcdMin);

  always_comb begin
    digit_o = digit_i;
    if (cb_i && inc_i)      digit_o = at_max ? BcdMin : digit_i + DigitWidth'(1);
    else if (cb_i && dec_i) digit_o = at_min ? BcdMax : digit_i - DigitWidth'(1);
  end

  assign carry_o  = cb_i & inc_i & at_max;
  assign borrow_o = cb_i & dec_i & at_min;
endmodule

// File: rtl/bcd_pulse_counter.sv
// Multi-digit BCD up/down counter driven by rising edges of debounced buttons.
// Define BCD_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module bcd_pulse_counter
  import bcd_counter_pkg::*;
#(
  parameter int                         NumDigits   = 4,
  parameter logic [4*NumDigits-1:0]     PresetValue = '0
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [3:0]                    DataIn,
  output logic [4*NumDigits-1:0]        Count,
  output logic                          Overflow,
  output logic                          Underflow
);
  logic [3:0] prev_q, rise;
  logic [NumDigits-1:0][DigitWidth-1:0] count_q, count_d, step_d;
  logic [NumDigits:0]   cb;
  logic [NumDigits-1:0] carry, borrow;
  logic do_inc, do_dec, wrap;
  logic ovf_q, ovf_d, udf_q, udf_d;

  assign rise   = DataIn & ~prev_q;
  assign do_inc = rise[IncBit] & ~rise[DecBit];
  assign do_dec = rise[DecBit] & ~rise[IncBit];

  // Digit 0 always steps; higher digits step only when every lower digit wrapped.
  assign cb[0] = 1'b1;
  for (genvar g = 0; g < NumDigits; g++) begin : g_digit
    bcd_digit u_digit (
      .digit_i  (count_q[g]),
      .inc_i    (do_inc),
      .dec_i    (do_dec),
      .cb_i     (cb[g]),
      .digit_o  (step_d[g]),
      .carry_o  (carry[g]),
      .borrow_o (borrow[g])
    );
    assign cb[g+1] = carry[g] | borrow[g];
  end
  assign wrap = cb[NumDigits];

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (rise[ClearBit]) begin
      count_d = '0;
    end else if (rise[LoadBit]) begin
      count_d = PresetValue;
    end else begin
      ovf_d = wrap & do_inc;
      udf_d = wrap & do_dec;
`ifdef BCD_COUNTER_SATURATE_EN
      if (!wrap) count_d = step_d;
`else
      count_d = step_d;
`endif
    end
  end

  // prev resets to all-ones so a button held through reset release is not an event.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      prev_q  <= 4'b1111;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      prev_q  <= DataIn;
    end
  end

  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;
endmodule

// File: tb/tb_bcd_pulse_counter.sv
// Scoreboard bench for bcd_pulse_counter against an integer-valued reference model.
module tb_bcd_pulse_counter;
  localparam int ND = 4;
  localparam int W  = 4*ND;
  localparam logic [W-1:0] PRESET = 16'h1234;
  localparam int PRESET_INT = 1234;
  localparam int MAXV = 9999;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [3:0]   DataIn;
  logic [W-1:0] Count;
  logic         Overflow, Underflow;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         ovf;
    logic         udf;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_val;
  logic [3:0] m_prev;

  bcd_pulse_counter #(.NumDigits(ND), .PresetValue(PRESET)) dut (
    .Clk(Clk), .Reset(Reset), .DataIn(DataIn),
    .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_prev = 4'b1111;
    exp_q.delete();
  endtask

  // Drive one cycle of DataIn (called at a negedge) and queue the expected result.
  task automatic step(input logic [3:0] din);
    logic [3:0] rise;
    exp_t e;
    DataIn = din;
    rise   = din & ~m_prev;
    m_prev = din;
    e.ovf  = 1'b0;
    e.udf  = 1'b0;
    if (rise[2]) m_val = 0;
    else if (rise[3]) m_val = PRESET_INT;
    else if (rise[0] && !rise[1]) begin
      if (m_val == MAXV) begin
        e.ovf = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
        m_val = MAXV;
`else
        m_val = 0;
`endif
      end else m_val = m_val + 1;
    end else if (rise[1] && !rise[0]) begin
      if (m_val == 0) begin
        e.udf = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
        m_val = 0;
`else
        m_val = MAXV;
`endif
      end else m_val = m_val - 1;
    end
    e.cnt = to_bcd(m_val);
    exp_q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic pulse(input logic [3:0] b);
    step(b);
    step(4'b0000);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) pulse(4'b0001);
  endtask

  // Monitor: the counter presents a result every clock, so one entry is consumed per edge.
  always @(posedge Clk) begin : monitor
    exp_t e;
    logic bad_nib;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bad_nib = 1'b0;
      for (int i = 0; i < ND; i++) if (Count[4*i +: 4] > 4'd9) bad_nib = 1'b1;
      n_checks++;
      if (Count !== e.cnt || Overflow !== e.ovf || Underflow !== e.udf || bad_nib) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got count=%h ovf=%b udf=%b, expected count=%h ovf=%b udf=%b",
                 $time, Count, Overflow, Underflow, e.cnt, e.ovf, e.udf);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] d;
    int r;
    Reset  = 1'b1;
    DataIn = 4'b0001;
    model_reset();
    #1;
    n_checks++;
    if (Count !== '0 || Overflow !== 1'b0 || Underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got count=%h ovf=%b udf=%b, expected 0/0/0", Count, Overflow, Underflow);
    end
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Button held through reset release: no event.
    repeat (3) step(4'b0001);
    step(4'b0000);
    pulse(4'b0001);

    // Ripple carries 0009->0010 and 0999->1000.
    pulse(4'b0100);
    incs(1000);

    // Wrap / saturate at both ends.
    pulse(4'b0100);
    pulse(4'b0010);
    pulse(4'b0001);
    pulse(4'b0100);
    pulse(4'b0010);
    pulse(4'b0010);

    // Held Inc advances once; simultaneous Inc+Dec is ignored; priority Clear > Load > Inc.
    pulse(4'b0100);
    repeat (10) step(4'b0001);
    step(4'b0000);
    pulse(4'b0100);
    incs(42);
    pulse(4'b0011);
    pulse(4'b1101);
    pulse(4'b1000);
    pulse(4'b1001);

    // Random walk, mostly Inc/Dec so both limits get crossed.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      d = 4'b0000;
      else if (r < 65) d = 4'b0001;
      else if (r < 90) d = 4'b0010;
      else if (r < 94) d = 4'b0011;
      else             d = 4'($urandom);
      step(d);
    end

    // Asynchronous reset between edges with a non-zero count.
    pulse(4'b0100);
    incs(777);
    step(4'b0000);
    @(posedge Clk);
    #3;
    Reset  = 1'b1;
    DataIn = 4'b0001;
    #1;
    n_checks++;
    if (Count !== '0 || Overflow !== 1'b0 || Underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got count=%h ovf=%b udf=%b, expected 0/0/0 before next edge",
               Count, Overflow, Underflow);
    end
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) step(4'b0001);
    step(4'b0000);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0010);

    step(4'b0000);
    @(posedge Clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected results left unconsumed, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
